// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file types and constants for the MIPS datapath.
package mips_pkg;
   typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;
   localparam int RF_DATA_W = 32;
   localparam int REG_ZERO = 0;
endpackage

// File: rtl/mips_rf_bypass.sv
// mips_rf_bypass: per-read-port forwarding of a same-cycle accepted write.
module mips_rf_bypass #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic [DATA_W-1:0] rd_data_o
);
   assign rd_data_o = (wr_en_i && wr_addr_i == rd_addr_i) ? wr_data_i : rd_data_i;
endmodule

// File: rtl/mips_register_file_multiport.sv
// mips_register_file_multiport: DEPTH x DATA_W register file, NUM_RD async reads, one write,
// hardware clear sequencer after reset, register 0 hardwired to zero.
module mips_register_file_multiport
   import mips_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] read_reg,
   output logic [NUM_RD*DATA_W-1:0] read_data,
   input  logic                     signal_reg_write,
   input  logic [ADDR_W-1:0]        write_reg,
   input  logic [DATA_W-1:0]        write_data,
   output logic                     ready,
   output logic                     write_drop
);
   localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
   rf_state_e state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic drop_q, drop_d;
   logic wr_nz, wr_in, wr_ok;
   logic [DATA_W-1:0] mem_q [1:DEPTH-1];
   assign ready      = state_q == RF_READY;
   assign write_drop = drop_q;
   assign wr_nz      = write_reg != ADDR_W'(REG_ZERO);
   assign wr_in      = {1'b0, write_reg} < LIMIT;
   assign wr_ok      = signal_reg_write && ready && wr_nz && wr_in;
   always_comb begin
      state_d = (state_q == RF_CLEAR && cnt_q == LAST) ? RF_READY : state_q;
      cnt_d   = (state_q == RF_CLEAR) ? cnt_q + 1'b1 : cnt_q;
      drop_d  = signal_reg_write && ((wr_nz && !ready) || !wr_in);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RF_CLEAR;
         cnt_q   <= (ADDR_W+1)'(1);
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end
   // Storage has no reset; the clear sequencer owns it until READY.
   always_ff @(posedge clk) begin
      if (state_q == RF_CLEAR)
         mem_q[cnt_q[ADDR_W-1:0]] <= '0;
      else if (wr_ok)
         mem_q[write_reg] <= write_data;
   end
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] arr;
      assign addr = read_reg[i*ADDR_W +: ADDR_W];
      assign arr  = (ready && addr != ADDR_W'(REG_ZERO) && {1'b0, addr} < LIMIT) ? mem_q[addr] : '0;
      mips_rf_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp (
         .rd_addr_i(addr),
         .wr_en_i  ((BYPASS != 0) && wr_ok),
         .wr_addr_i(write_reg),
         .wr_data_i(write_data),
         .rd_data_i(arr),
         .rd_data_o(read_data[i*DATA_W +: DATA_W])
      );
   end
endmodule

// File: tb/tb_mips_register_file_multiport.sv
// tb_mips_register_file_multiport: directed checks on bypassing, non-bypassing and DEPTH=20 instances.
module tb_mips_register_file_multiport;
   localparam int AW = 5;
   localparam int DW = 32;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [2*AW-1:0] rreg = '0;
   logic we = 1'b0;
   logic [AW-1:0] wreg = '0;
   logic [DW-1:0] wdata = '0;
   logic [2*DW-1:0] rd_b, rd_n, rd_s;
   logic rdy_b, rdy_n, rdy_s, drop_b, drop_n, drop_s;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mips_register_file_multiport #(.DEPTH(32), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .read_reg(rreg), .read_data(rd_b), .signal_reg_write(we),
      .write_reg(wreg), .write_data(wdata), .ready(rdy_b), .write_drop(drop_b));
   mips_register_file_multiport #(.DEPTH(32), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .read_reg(rreg), .read_data(rd_n), .signal_reg_write(we),
      .write_reg(wreg), .write_data(wdata), .ready(rdy_n), .write_drop(drop_n));
   mips_register_file_multiport #(.DEPTH(20), .BYPASS(1)) dut20 (
      .clk(clk), .rst(rst), .read_reg(rreg), .read_data(rd_s), .signal_reg_write(we),
      .write_reg(wreg), .write_data(wdata), .ready(rdy_s), .write_drop(drop_s));

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
      rreg = {a1, a0};
      #1;
   endtask

   task automatic clear_run(input string tag);
      for (int n = 1; n <= 31; n++) begin
         tick();
         check({tag, "_ready"}, {31'd0, rdy_b}, {31'd0, n >= 31});
         check({tag, "_ready20"}, {31'd0, rdy_s}, {31'd0, n >= 19});
      end
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      check("rst_ready", {31'd0, rdy_b}, 32'd0);
      check("rst_drop", {31'd0, drop_b}, 32'd0);
      rd(5'd3, 5'd1);
      check("rst_rd0", rd_b[31:0], 32'd0);
      check("rst_rd1", rd_b[63:32], 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      we = 1'b1; wreg = 5'd3; wdata = 32'h0BAD_0003;
      for (int n = 1; n <= 31; n++) begin
         tick();
         we = 1'b0;
         check("clr_ready", {31'd0, rdy_b}, {31'd0, n >= 31});
         check("clr_ready_nb", {31'd0, rdy_n}, {31'd0, n >= 31});
         check("clr_ready20", {31'd0, rdy_s}, {31'd0, n >= 19});
         if (n <= 2) check("clr_drop", {31'd0, drop_b}, {31'd0, n == 1});
         if (n == 5) begin
            rd(5'd30, 5'd3);
            check("clr_forced0", rd_b[31:0], 32'd0);
            check("clr_forced1", rd_b[63:32], 32'd0);
         end
      end
      for (int a = 0; a < 32; a++) begin
         rd(5'd0, AW'(a));
         check("zero_after_clear", rd_b[31:0], 32'd0);
      end
      we = 1'b1; wreg = 5'd5; wdata = 32'hDEAD_BEEF;
      tick();
      we = 1'b0;
      rd(5'd5, 5'd5);
      check("r5_p0", rd_b[31:0], 32'hDEAD_BEEF);
      check("r5_p1", rd_b[63:32], 32'hDEAD_BEEF);
      check("r5_nb", rd_n[63:32], 32'hDEAD_BEEF);
      we = 1'b1; wreg = 5'd0; wdata = 32'h1234_5678;
      tick();
      we = 1'b0;
      check("r0_nodrop", {31'd0, drop_b}, 32'd0);
      rd(5'd0, 5'd0);
      check("r0_zero", rd_b[31:0], 32'd0);
      rd(5'd7, 5'd0);
      we = 1'b1; wreg = 5'd7; wdata = 32'hA5A5_A5A5;
      #1;
      check("byp_same", rd_b[63:32], 32'hA5A5_A5A5);
      check("nobyp_same", rd_n[63:32], 32'd0);
      tick();
      we = 1'b0;
      #1;
      check("nobyp_next", rd_n[63:32], 32'hA5A5_A5A5);
      check("byp_next", rd_b[63:32], 32'hA5A5_A5A5);
      we = 1'b1; wreg = 5'd25; wdata = 32'h2525_2525;
      tick();
      we = 1'b0;
      check("d20_drop", {31'd0, drop_s}, 32'd1);
      check("d32_nodrop", {31'd0, drop_b}, 32'd0);
      rd(5'd0, 5'd25);
      check("d20_r25", rd_s[31:0], 32'd0);
      check("d32_r25", rd_b[31:0], 32'h2525_2525);
      tick();
      check("d20_drop_end", {31'd0, drop_s}, 32'd0);
      we = 1'b1; wreg = 5'd9; wdata = 32'h0000_0099;
      tick();
      we = 1'b0;
      rd(5'd9, 5'd9);
      check("r9_set", rd_b[31:0], 32'h0000_0099);
      #2 rst = 1'b1;
      #1;
      check("async_ready", {31'd0, rdy_b}, 32'd0);
      check("async_rd", rd_b[31:0], 32'd0);
      tick();
      rst = 1'b0;
      repeat (10) tick();
      check("mid_ready", {31'd0, rdy_b}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ready20", {31'd0, rdy_s}, 32'd0);
      tick();
      rst = 1'b0;
      clear_run("restart");
      rd(5'd9, 5'd9);
      check("r9_cleared_p0", rd_b[31:0], 32'd0);
      check("r9_cleared_p1", rd_n[63:32], 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
